sram_bridge: RTL

Bridges the MEM stage's memory request bus to the board's external 32-bit asynchronous SRAM. It takes the MEM-stage request (chip enable, write enable, byte selects, address, store data) and runs a multi-cycle SRAM read or write. It returns one `ready_o` pulse per access and load data that stays stable after the pulse. This matches the MEM stage's two-phase `cnt` protocol: the stage stalls until ready, then reads the data one cycle later with its enable dropped.

---
 rtl/sram_bridge.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sram_bridge.sv
// sram_bridge
//   Bridges the MEM-stage request bus to an external 32-bit asynchronous SRAM.
//   A level request on ce_i starts one SRAM read or write. The transfer runs
//   through SETUP, WAIT_CYCLES ACCESS cycles and DONE. DONE gives one ready_o
//   pulse. HOLD then waits for ce_i to drop before another request is taken.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-low
//   ce_i          request valid (level)
//   we_i          1 = write, 0 = read
//   addr_i        byte address; word address is addr_i[ADDR_W+1:2]
//   sel_i         byte lane enables
//   wdata_i       lane-aligned store data
//   rdata_o       load data register, changes only on read capture
//   ready_o       one-cycle completion pulse
//   sram_addr_o   SRAM word address
//   sram_data_io  SRAM bidirectional data bus
//   sram_ce_n     SRAM chip enable, active-low
//   sram_oe_n     SRAM output enable, active-low
//   sram_we_n     SRAM write strobe, active-low
//   sram_be_n     SRAM byte enables, active-low

module sram_bridge #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ready_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [31:0]       sram_data_io,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                cnt_last;
    logic                we_q;
    logic                drive_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                ready_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                ce_n_q;
    logic                oe_n_q;
    logic                we_n_q;
    logic [3:0]          be_n_q;

    // Byte-offset and out-of-range address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    assign cnt_d    = cnt_q + CNT_W'(1);
    assign cnt_last = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            drive_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ce_i) begin
                        // Latch the whole request; later changes on the
                        // inputs are ignored until the next access.
                        state_q <= SETUP;
                        we_q    <= we_i;
                        wdata_q <= wdata_i;
                        addr_q  <= addr_i[ADDR_W+1:2];
                        be_n_q  <= ~sel_i;
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= we_i;   // reads enable the output at SETUP
                        drive_q <= we_i;   // writes put data on the bus at SETUP
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    cnt_q   <= '0;
                    we_n_q  <= ~we_q;
                end
                ACCESS: begin
                    if (cnt_last) begin
                        state_q <= DONE;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        ready_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= sram_data_io;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    // Data stays driven through DONE for hold after we_n rises.
                    state_q <= HOLD;
                    ready_q <= 1'b0;
                    ce_n_q  <= 1'b1;
                    be_n_q  <= 4'hF;
                    drive_q <= 1'b0;
                    cnt_q   <= '0;
                end
                HOLD: begin
                    // A request still held high must not start a second access.
                    if (!ce_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sram_data_io = drive_q ? wdata_q : 32'hzzzz_zzzz;

    assign rdata_o     = rdata_q;
    assign ready_o     = ready_q;
    assign sram_addr_o = addr_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_be_n   = be_n_q;

endmodule
